// File: rtl/pico_ctrl_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pico_ctrl_sequencer_pkg
//   Shared definitions for the PicoCtrl sequencer: FSM states, instruction
//   field layout and the opcode field constants.
//   Instruction word: [15:13] cond_sel, [12] cond_val, [11:10] action,
//                     [9:8] reg, [7:0] imm.
// ---------------------------------------------------------------------------
package pico_ctrl_sequencer_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] cond_sel;
    logic       cond_val;
    logic [1:0] action;
    logic [1:0] rsel;
    logic [7:0] imm;
  } instr_t;

  // Condition field: {cond_sel, cond_val}; c[0] is tied low so 0/0 is "always".
  localparam logic [3:0] IF_ALWAYS  = 4'b0000;
  localparam logic [3:0] IF_C1_EQ_1 = 4'b0011;

  localparam logic [1:0] THEN_NOP   = 2'b00;
  localparam logic [1:0] THEN_WRITE = 2'b01;
  localparam logic [1:0] THEN_JUMP  = 2'b10;
  localparam logic [1:0] THEN_CALL  = 2'b11;

  localparam logic [1:0] TO_REG_0 = 2'b00;
  localparam logic [1:0] TO_REG_1 = 2'b01;
  localparam logic [1:0] TO_REG_2 = 2'b10;
  localparam logic [1:0] TO_REG_3 = 2'b11;

  // Sub-operations of action 11, selected by the reg field.
  localparam logic [1:0] SUB_CALL = 2'b00;
  localparam logic [1:0] SUB_RET  = 2'b01;

  localparam logic [15:0] NOP = 16'h0000;

  localparam int STACK_DEPTH = 4;

endpackage

// File: rtl/pico_cond_sync.sv
// ---------------------------------------------------------------------------
// pico_cond_sync
//   NSYNC-deep flop synchroniser for the external condition inputs.
//   Ports:
//     clk     in  1      rising-edge clock
//     reset   in  1      asynchronous, active-high; clears every stage
//     i_cond  in  WIDTH  raw asynchronous inputs
//     o_cond  out WIDTH  synchronised copy (last stage)
// ---------------------------------------------------------------------------
module pico_cond_sync #(
  parameter int NSYNC = 2,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_cond,
  output logic [WIDTH-1:0] o_cond
);

  logic [NSYNC-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_cond;
      for (int i = 1; i < NSYNC; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_cond = r_stage[NSYNC-1];

endmodule

// File: rtl/pico_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// pico_ctrl_sequencer
//   Fetch/execute engine of PicoCtrl. Two cycles per instruction (FETCH,
//   EXEC). In EXEC the ROM word is decoded and, if its condition holds on the
//   synchronised inputs, writes an immediate to one of four output registers
//   or jumps.
//   Optional feature macro: PICO_CALL_EN -- enables call/return (action 11)
//   with a 4-entry circular return stack. Without it action 11 is a nop.
//   Ports:
//     clk       in  1         rising-edge clock
//     reset     in  1         asynchronous, active-high
//     en        in  1         1 = run; 0 = hold in FETCH
//     rom_addr  out ADDR_W    registered PC
//     rom_data  in  16        instruction word for rom_addr
//     cond_in   in  7         condition bits c[7:1] (cond_in[0] = c[1])
//     out_reg   out 4*DATA_W  register r at [8r+7:8r]
//     out_wr    out 4         one-cycle write strobe, aligned with out_reg
// ---------------------------------------------------------------------------
module pico_ctrl_sequencer
  import pico_ctrl_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int NSYNC  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [15:0]         rom_data,
  input  logic [6:0]          cond_in,
  output logic [4*DATA_W-1:0] out_reg,
  output logic [3:0]          out_wr
);

  state_t                  r_state, w_state_next;
  logic [ADDR_W-1:0]       r_pc, w_pc_next, w_pc_inc;
  logic [3:0][DATA_W-1:0]  r_out, w_out_next;
  logic [3:0]              r_wr, w_wr_next;
  logic [6:0]              w_c_sync;
  logic [7:0]              w_c;
  instr_t                  w_instr;
  logic                    w_cond;

  pico_cond_sync #(
    .NSYNC (NSYNC),
    .WIDTH (7)
  ) u_cond_sync (
    .clk    (clk),
    .reset  (reset),
    .i_cond (cond_in),
    .o_cond (w_c_sync)
  );

  assign w_c      = {w_c_sync, 1'b0};
  assign w_instr  = instr_t'(rom_data);
  assign w_cond   = (w_c[w_instr.cond_sel] == w_instr.cond_val);
  assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef PICO_CALL_EN
  // Circular return stack: r_sp is the next write slot, r_cnt saturates at
  // the depth, so a push when full lands on the oldest entry.
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [1:0]        r_sp;
  logic [2:0]        r_cnt;
  logic [1:0]        w_sp_top;
  logic              w_push, w_pop;

  assign w_sp_top = r_sp - 2'd1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_out_next   = r_out;
    w_wr_next    = '0;
`ifdef PICO_CALL_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        if (en) w_state_next = EXEC;
      end
      EXEC: begin
        // The instruction always completes, regardless of en.
        w_state_next = FETCH;
        w_pc_next    = w_pc_inc;
        if (w_cond) begin
          case (w_instr.action)
            THEN_WRITE: begin
              w_out_next[w_instr.rsel] = w_instr.imm;
              w_wr_next[w_instr.rsel]  = 1'b1;
            end
            THEN_JUMP: w_pc_next = w_instr.imm[ADDR_W-1:0];
`ifdef PICO_CALL_EN
            THEN_CALL: begin
              if (w_instr.rsel == SUB_CALL) begin
                w_push    = 1'b1;
                w_pc_next = w_instr.imm[ADDR_W-1:0];
              end else if (w_instr.rsel == SUB_RET) begin
                w_pop     = 1'b1;
                w_pc_next = (r_cnt == 3'd0) ? '0 : r_stack[w_sp_top];
              end
            end
`endif
            default: ;
          endcase
        end
      end
      default: w_state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_out   <= '0;
      r_wr    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_out   <= w_out_next;
      r_wr    <= w_wr_next;
    end
  end

`ifdef PICO_CALL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (w_push) begin
      r_stack[r_sp] <= w_pc_inc;
      r_sp          <= r_sp + 2'd1;
      if (r_cnt != 3'(STACK_DEPTH)) r_cnt <= r_cnt + 3'd1;
    end else if (w_pop && (r_cnt != 3'd0)) begin
      r_sp  <= w_sp_top;
      r_cnt <= r_cnt - 3'd1;
    end
  end
`endif

  assign rom_addr = r_pc;
  assign out_reg  = r_out;
  assign out_wr   = r_wr;

endmodule

// File: tb/tb_pico_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pico_ctrl_sequencer
//   Directed scenarios followed by randomized programs, checked against an
//   instruction-level reference model (PC, four registers, return-stack queue).
// ---------------------------------------------------------------------------
module tb_pico_ctrl_sequencer;

  localparam int ADDR_W = 5;
  localparam int NSYNC  = 2;
  localparam int ROM_N  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [6:0]  cond_in;
  logic [31:0] out_reg;
  logic [3:0]  out_wr;

  logic [15:0] rom [ROM_N];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  pico_ctrl_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (8),
    .NSYNC  (NSYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cond_in  (cond_in),
    .out_reg  (out_reg),
    .out_wr   (out_wr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_pc;
  logic [7:0] m_regs [4];
  int         m_stack [$];
  logic [6:0] m_cond;

  function automatic logic [31:0] model_out();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_stack.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Executes one instruction in the model, returning the expected strobe.
  task automatic model_exec(input logic [15:0] w, output logic [3:0] exp_wr);
    logic [7:0] c;
    int         nxt;
    c      = {m_cond, 1'b0};
    exp_wr = 4'b0000;
    nxt    = (m_pc + 1) % ROM_N;
    if (c[w[15:13]] == w[12]) begin
      case (w[11:10])
        2'b01: begin
          m_regs[w[9:8]] = w[7:0];
          exp_wr[w[9:8]] = 1'b1;
        end
        2'b10: nxt = int'(w[7:0]) % ROM_N;
`ifdef PICO_CALL_EN
        2'b11: begin
          if (w[9:8] == 2'b00) begin
            if (m_stack.size() == 4) void'(m_stack.pop_front());
            m_stack.push_back((m_pc + 1) % ROM_N);
            nxt = int'(w[7:0]) % ROM_N;
          end else if (w[9:8] == 2'b01) begin
            nxt = (m_stack.size() == 0) ? 0 : m_stack.pop_back();
          end
        end
`endif
        default: ;
      endcase
    end
    m_pc = nxt;
  endtask

  // Called at a FETCH point (1 time unit after a posedge, en already 1).
  task automatic step_instr(input bit drop_en);
    logic [3:0] exp_wr;
    chk("fetch_addr", 32'(rom_addr), 32'(m_pc));
    @(posedge clk); #1;
    chk("exec_addr", 32'(rom_addr), 32'(m_pc));
    chk("exec_wr_idle", 32'(out_wr), 32'd0);
    if (drop_en) en = 1'b0;
    model_exec(rom[m_pc], exp_wr);
    @(posedge clk); #1;
    chk("wr_strobe", 32'(out_wr), 32'(exp_wr));
    chk("out_reg", out_reg, model_out());
    if (drop_en) begin
      repeat (5) begin
        @(posedge clk); #1;
        chk("en_hold_addr", 32'(rom_addr), 32'(m_pc));
        chk("en_hold_wr", 32'(out_wr), 32'd0);
      end
      en = 1'b1;
    end
  endtask

  // Changes the condition inputs while parked in FETCH, long enough for
  // the synchroniser to settle before the next EXEC.
  task automatic set_cond(input logic [6:0] v);
    en      = 1'b0;
    cond_in = v;
    m_cond  = v;
    repeat (NSYNC + 2) begin
      @(posedge clk); #1;
      chk("idle_addr", 32'(rom_addr), 32'(m_pc));
      chk("idle_wr", 32'(out_wr), 32'd0);
    end
    en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [15:0] w;

    reset   = 1'b1;
    en      = 1'b0;
    cond_in = 7'h00;
    m_cond  = 7'h00;
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'h0000;
    model_reset();

    // Reset state
    #12;
    chk("reset_addr", 32'(rom_addr), 32'd0);
    chk("reset_out_reg", out_reg, 32'd0);
    chk("reset_out_wr", 32'(out_wr), 32'd0);
    #5;
    reset = 1'b0;

    // 1: always write reg1 <= 01, then nop
    rom[0] = 16'h0501;
    rom[1] = 16'h0000;
    en = 1'b1;
    step_instr(1'b0);
    chk("t1_reg1", 32'(out_reg[15:8]), 32'h01);
    chk("t1_strobe", 32'(out_wr), 32'b0010);

    // 2: busy wait on c1 == 1, then release
    rom[1] = 16'h3801;
    set_cond(7'h01);
    repeat (10) step_instr(1'b0);
    chk("t2_held", 32'(rom_addr), 32'd1);
    cond_in = 7'h00;
    k = 0;
    while (k < NSYNC + 2 && rom_addr != 5'd2) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t2_advance", 32'(rom_addr), 32'd2);
    m_cond = 7'h00;
    m_pc   = 2;

    // 3: jump with high imm bits ignored (0xFF -> 31), nop at 31 wraps to 0
    rom[2]  = 16'h08FF;
    rom[31] = 16'h0000;
    step_instr(1'b0);
    chk("t3_at_31", 32'(rom_addr), 32'd31);
    step_instr(1'b0);
    chk("t3_wrap", 32'(rom_addr), 32'd0);

    // 4: en dropped during EXEC of a write
    rom[0] = 16'h065A;
    step_instr(1'b1);
    chk("t4_reg2", 32'(out_reg[23:16]), 32'h5A);

    // 5: reset in EXEC of a write while reg0 holds 80
    rom[1] = 16'h0480;
    rom[2] = 16'h0733;
    step_instr(1'b0);
    chk("t5_pre", 32'(out_reg[7:0]), 32'h80);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t5_out_reg", out_reg, 32'd0);
    chk("t5_out_wr", 32'(out_wr), 32'd0);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'h0000;

`ifdef PICO_CALL_EN
    // 6: call/return, then five nested calls and five returns
    rom[3]  = 16'h0C10;
    rom[16] = 16'h0D00;
    repeat (4) step_instr(1'b0);
    chk("t6_call", 32'(rom_addr), 32'h10);
    step_instr(1'b0);
    chk("t6_ret", 32'(rom_addr), 32'd4);
    rom[4]  = 16'h0C08;
    rom[8]  = 16'h0C0C;
    rom[12] = 16'h0C10;
    rom[16] = 16'h0C14;
    rom[20] = 16'h0C18;
    rom[24] = 16'h0D00;
    rom[21] = 16'h0D00;
    rom[17] = 16'h0D00;
    rom[13] = 16'h0D00;
    rom[9]  = 16'h0D00;
    repeat (9) step_instr(1'b0);
    chk("t6_last_ret_prev", 32'(rom_addr), 32'd9);
    step_instr(1'b0);
    chk("t6_empty_ret", 32'(rom_addr), 32'd0);
`else
    // Action 11 behaves as a nop in the default build
    rom[0] = 16'h0C10;
    rom[1] = 16'h0D00;
    step_instr(1'b0);
    chk("t6_nop_call", 32'(rom_addr), 32'd1);
    step_instr(1'b0);
    chk("t6_nop_ret", 32'(rom_addr), 32'd2);
`endif

    // Randomized programs and condition patterns
    for (int blk = 0; blk < 8; blk++) begin
      set_cond(7'($urandom_range(0, 127)));
      for (int i = 0; i < ROM_N; i++) begin
        w = 16'($urandom);
        rom[i] = w;
      end
      for (int s = 0; s < 16; s++) begin
        step_instr($urandom_range(0, 7) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
